// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_pkg
// Purpose  : Shared widths, zero-register constant and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEFER = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Deferred-write FIFO with occupancy and per-entry rd visibility.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [REG_AW-1:0]          push_rd_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [REG_AW-1:0]          head_rd_o,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [DEPTH-1:0]           vld_o,
    output logic [DEPTH*REG_AW-1:0]    rd_flat_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [REG_AW-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              w_do_push, w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = w_do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - 1'b1;
        end
        // Clear before set: a full-cycle push/pop never shares a slot, but order is safe anyway.
        vld_d = vld_q;
        if (w_do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (w_do_push) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            rd_mem_q[wr_ptr_q]   <= push_rd_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_rd_o   = rd_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign vld_o       = vld_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign rd_flat_o[gi*REG_AW +: REG_AW] = rd_mem_q[gi];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares one register-bank write port between the pipeline WB stage
//            and a buffered multi-cycle unit, with starvation-driven stalls.
// Revision : 1.0
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p_we,
    input  logic [REG_AW-1:0]      p_rd,
    input  logic [DATA_W-1:0]      p_data,
    input  logic                   m_valid,
    input  logic [REG_AW-1:0]      m_rd,
    input  logic [DATA_W-1:0]      m_data,
    output logic                   m_ready,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   stall_pipe,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            busy_mask
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e                 state_q, state_d;
    logic [SW-1:0]              starve_q, starve_d;

    logic                       w_fifo_full, w_fifo_empty;
    logic [REG_AW-1:0]          w_head_rd;
    logic [DATA_W-1:0]          w_head_data;
    logic [DEPTH-1:0]           w_vld;
    logic [DEPTH*REG_AW-1:0]    w_rd_flat;
    logic                       w_pipe_req, w_grant_fifo, w_grant_pipe;
    logic                       w_push, w_pop, w_nonempty_next, w_starve_hit;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_rd_i   (m_rd),
        .push_data_i (m_data),
        .pop_i       (w_pop),
        .head_rd_o   (w_head_rd),
        .head_data_o (w_head_data),
        .count_o     (fifo_count),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .vld_o       (w_vld),
        .rd_flat_o   (w_rd_flat)
    );

    assign stall_pipe   = (state_q == ST_FORCE);
    assign w_pipe_req   = p_we && (p_rd != ZERO_REG);
    assign w_grant_fifo = rst && !w_fifo_empty && (stall_pipe || !w_pipe_req);
    assign w_grant_pipe = rst && !w_grant_fifo && w_pipe_req;
    assign w_pop        = w_grant_fifo;

    // x0 targets are acknowledged but never buffered.
    assign m_ready = rst && !w_fifo_full;
    assign w_push  = m_valid && m_ready && (m_rd != ZERO_REG);

    assign rf_we    = w_grant_fifo || w_grant_pipe;
    assign rf_rd    = w_grant_fifo ? w_head_rd   : (w_grant_pipe ? p_rd   : ZERO_REG);
    assign rf_wdata = w_grant_fifo ? w_head_data : (w_grant_pipe ? p_data : '0);

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i]) begin
                busy_mask[w_rd_flat[i*REG_AW +: REG_AW]] = 1'b1;
            end
        end
    end

    assign w_nonempty_next = w_push || (fifo_count > 1) || ((fifo_count == 1) && !w_pop);
    assign w_starve_hit    = (state_q == ST_DEFER) && w_grant_pipe &&
                             (starve_q == SW'(STARVE_MAX - 1));

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (w_fifo_empty || w_pop || w_starve_hit) begin
            starve_d = '0;
        end else if (w_grant_pipe) begin
            starve_d = starve_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (w_push) begin
                    state_d = ST_DEFER;
                end
            end
            ST_DEFER: begin
                if (w_starve_hit) begin
                    state_d = ST_FORCE;
                end else if (!w_nonempty_next) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FORCE: begin
                state_d = w_nonempty_next ? ST_DEFER : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: deferred-write FIFO entries for the multi-cycle source.
REQ-002 Parameter STARVE_MAX, default 3: consecutive deferred cycles before the pipeline is stalled.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset; state clears while rst=0.
REQ-005 p_we  in  1  pipeline writeback enable.
REQ-006 p_rd  in  5  pipeline destination register.
REQ-007 p_data  in  32  pipeline writeback data.
REQ-008 m_valid  in  1  multi-cycle unit result valid.
REQ-009 m_rd  in  5  multi-cycle unit destination register.
REQ-010 m_data  in  32  multi-cycle unit result data.
REQ-011 m_ready  out  1  FIFO can accept; a transfer occurs when m_valid=1 and m_ready=1.
REQ-012 rf_we  out  1  register-bank write enable.
REQ-013 rf_rd  out  5  register-bank write address.
REQ-014 rf_wdata  out  32  register-bank write data.
REQ-015 stall_pipe  out  1  registered one-cycle request to hold the pipeline WB stage.
REQ-016 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 busy_mask  out  32  bit r set iff some FIFO entry targets register r.

Function
REQ-018 rf_we, rf_rd and rf_wdata SHALL be combinational from the current grant (zero latency), so the bank writes on the same posedge.
REQ-019 Grant priority: if stall_pipe=1 and the FIFO is non-empty, the FIFO head is granted; else, if p_we=1 and p_rd!=0, the pipeline is granted; else, if the FIFO is non-empty, the FIFO head is granted; else rf_we=0.
REQ-020 A pipeline write with p_rd=0 SHALL NOT produce rf_we=1 and leaves the port free for the FIFO head in that cycle.
REQ-021 m_ready SHALL equal (fifo_count < DEPTH); a push while full is impossible even if a pop occurs in the same cycle.
REQ-022 A transfer with m_rd=0 SHALL be accepted and discarded without a push.
REQ-023 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-024 The FIFO is popped exactly in cycles where its head is granted; the pointers wrap modulo DEPTH.
REQ-025 The starvation counter SHALL increment when the FIFO is non-empty and the pipeline is granted.
REQ-026 The starvation counter SHALL clear on any pop or when the FIFO is empty.
REQ-027 When the starvation counter reaches STARVE_MAX, stall_pipe SHALL be 1 in the next cycle only, and the counter SHALL clear.
REQ-028 During stall_pipe=1 the pipeline SHALL hold p_we/p_rd/p_data stable into the following cycle; the arbiter drops no pipeline write.
REQ-029 busy_mask SHALL be combinational from the valid FIFO entries; the pipeline uses it for RAW/WAW interlock, and the arbiter never reorders same-rd writes.
REQ-030 The states are IDLE (FIFO empty), DEFER (FIFO non-empty, counter < STARVE_MAX) and FORCE (stall_pipe=1).
REQ-031 Transitions: IDLE->DEFER on push; DEFER->FORCE when the counter hits STARVE_MAX; FORCE->DEFER or IDLE after one cycle, depending on occupancy; DEFER->IDLE on the last pop.

Reset
REQ-032 While rst=0: FIFO empty, pointers 0, fifo_count=0, counter=0, stall_pipe=0, m_ready=0, rf_we=0, busy_mask=0.
REQ-033 Reset mid-operation SHALL discard all FIFO contents with no rf_we pulse.
REQ-034 After rst deasserts, the first posedge may accept a push.

Structure
REQ-035 The shared package SHALL hold the register-address width (5), data width (32), the zero-register constant and the state enum.
REQ-036 One sub-module, wb_fifo (synchronous FIFO with count and per-entry rd visibility), SHALL implement the buffer.
REQ-037 Arbitration, starvation control and busy_mask SHALL reside in regfile_wb_arbiter.

Verification
REQ-038 Single push, no pipeline traffic: m_rd=5, m_data=0xDEADBEEF, with p_we=0 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, fifo_count back to 0.
REQ-039 Collision: pipeline p_rd=3, p_data=0x11 continuously while m_rd=7, m_data=0x22 is buffered -> three pipeline grants, then stall_pipe=1 for one cycle writing x7=0x22, then the held x3=0x11 write occurs.
REQ-040 Fill/full: push 2 entries with p_we busy -> m_ready=0, fifo_count=2, busy_mask bits set; a same-cycle pop keeps m_ready=0; the next cycle m_ready=1.
REQ-041 x0 handling: m_rd=0 transfer -> fifo_count stays 0; p_we=1 with p_rd=0 and one buffered entry -> rf_we writes the FIFO head that cycle.
REQ-042 Reset mid-operation: FIFO holds 2 entries and rst=0 -> outputs at reset values immediately, no write to the bank afterward.
REQ-043 Ordering: push rd=4 with 0xA then 0xB -> x4 written 0xA then 0xB, and busy_mask[4] clears after the second pop.
